split_data: RTL and testbench

SPLIT_DATA -- requirements
Module: split_data

---
 rtl/split_data_if.sv | 22 ++
 rtl/split_data.sv | 89 ++++++++
 tb/tb_split_data.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/split_data_if.sv
// Handshake bundle between a word source and split_data, and between split_data and a UART transmitter.
interface split_data_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] data_i;
  logic               start_i;
  logic               ready_o;
  logic [7:0]         data_uart_o;
  logic               uart_valid_o;
  logic               uart_ready_i;
  logic               split_finished_o;

  modport slave (
    input  data_i, start_i, uart_ready_i,
    output ready_o, data_uart_o, uart_valid_o, split_finished_o
  );

  modport master (
    output data_i, start_i, uart_ready_i,
    input  ready_o, data_uart_o, uart_valid_o, split_finished_o
  );
endinterface

// File: rtl/split_data.sv
// Serialises one {I,Q} word into UART bytes, MSB first, with valid/ready backpressure.
// Defining SPLIT_SYNC_HEADER_EN prepends SYNC_BYTE to every word.
//
// state | meaning
// IDLE  | ready for a new word
// SEND  | presenting bytes to the UART, shifting on each handshake
// DONE  | one-cycle split_finished_o pulse, then back to IDLE
module split_data #(
  parameter int         WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic         clk,
  input logic         rst,
  split_data_if.slave bus
);

  localparam int NB = 2*WIDTH/8;
`ifdef SPLIT_SYNC_HEADER_EN
  localparam int NB_TOT = NB + 1;
`else
  localparam int NB_TOT = NB;
`endif
  localparam int SW = 8*NB_TOT;
  localparam int CW = $clog2(NB_TOT+1);
  localparam logic [CW-1:0] LAST = CW'(NB_TOT-1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] load_word;
  logic          accept;
  logic          xfer;

`ifdef SPLIT_SYNC_HEADER_EN
  assign load_word = {SYNC_BYTE, bus.data_i};
`else
  assign load_word = bus.data_i;
`endif

  assign accept = (state_q == IDLE) && bus.start_i;
  assign xfer   = (state_q == SEND) && bus.uart_ready_i;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          shift_d = load_word;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output byte is always the top of the shift register, so it cannot move without a handshake.
  assign bus.data_uart_o      = shift_q[SW-1 -: 8];
  assign bus.uart_valid_o     = (state_q == SEND);
  assign bus.ready_o          = (state_q == IDLE);
  assign bus.split_finished_o = (state_q == DONE);

endmodule

// File: tb/tb_split_data.sv
// Directed bench for split_data (WIDTH=16); expectations follow SPLIT_SYNC_HEADER_EN when defined.
module tb_split_data;

`ifdef SPLIT_SYNC_HEADER_EN
  localparam int NBT = 5;
  localparam int HDR = 1;
`else
  localparam int NBT = 4;
  localparam int HDR = 0;
`endif

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  split_data_if #(.WIDTH(16)) bus ();

  split_data #(.WIDTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
    logic [7:0] b;
    if (HDR == 1 && i == 0) b = 8'hA5;
    else b = w[8*(NBT-1-i) +: 8];
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.data_i = 32'h0;
    bus.uart_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (bus.ready_o !== 1'b1 || bus.uart_valid_o !== 1'b0 ||
        bus.data_uart_o !== 8'h00 || bus.split_finished_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset: ready=%b valid=%b byte=%h fin=%b, want 1 0 00 0",
               bus.ready_o, bus.uart_valid_o, bus.data_uart_o, bus.split_finished_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] w;
    w = 32'h12345678;
    @(negedge clk);
    vec_cnt++;
    if (bus.ready_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_ready: got %b want 1", bus.ready_o);
    end
    bus.data_i = w;
    bus.start_i = 1'b1;
    bus.uart_ready_i = 1'b1;
    for (int i = 0; i < NBT; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      vec_cnt++;
      if (bus.uart_valid_o !== 1'b1 || bus.data_uart_o !== exp_byte(w, i) ||
          bus.split_finished_o !== 1'b0 || bus.ready_o !== 1'b0) begin
        err_cnt++;
        $display("FAIL basic_byte%0d: valid=%b byte=%h fin=%b ready=%b, want 1 %h 0 0",
                 i, bus.uart_valid_o, bus.data_uart_o, bus.split_finished_o,
                 bus.ready_o, exp_byte(w, i));
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.split_finished_o !== 1'b1 || bus.uart_valid_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_done: fin=%b valid=%b ready=%b, want 1 0 0",
               bus.split_finished_o, bus.uart_valid_o, bus.ready_o);
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.split_finished_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_idle: fin=%b ready=%b, want 0 1", bus.split_finished_o, bus.ready_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    int idx, stall, cyc;
    w = 32'h12345678;
    idx = 0;
    stall = 3;
    cyc = 0;
    bus.data_i = w;
    bus.start_i = 1'b1;
    bus.uart_ready_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (idx < NBT && cyc < 30) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      vec_cnt++;
      if (bus.uart_valid_o !== 1'b1 || bus.data_uart_o !== exp_byte(w, idx)) begin
        err_cnt++;
        $display("FAIL bp_byte%0d: valid=%b byte=%h, want 1 %h",
                 idx, bus.uart_valid_o, bus.data_uart_o, exp_byte(w, idx));
      end
      if (idx == HDR + 1 && stall > 0) begin
        bus.uart_ready_i = 1'b0;
        stall--;
      end else begin
        bus.uart_ready_i = 1'b1;
        idx++;
      end
    end
    vec_cnt++;
    if (cyc != NBT + 3) begin
      err_cnt++;
      $display("FAIL bp_cycles: got %0d want %0d", cyc, NBT + 3);
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.split_finished_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_done: fin=%b want 1", bus.split_finished_o);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa, wb;
    wa = 32'hFFFF0001;
    wb = 32'h80007FFF;
    bus.data_i = wa;
    bus.start_i = 1'b1;
    bus.uart_ready_i = 1'b1;
    for (int i = 0; i < NBT; i++) begin
      @(negedge clk);
      bus.data_i = wb;
      vec_cnt++;
      if (bus.uart_valid_o !== 1'b1 || bus.data_uart_o !== exp_byte(wa, i)) begin
        err_cnt++;
        $display("FAIL b2b_a%0d: valid=%b byte=%h, want 1 %h",
                 i, bus.uart_valid_o, bus.data_uart_o, exp_byte(wa, i));
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.split_finished_o !== 1'b1 || bus.ready_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_done_a: fin=%b ready=%b, want 1 0", bus.split_finished_o, bus.ready_o);
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.ready_o !== 1'b1 || bus.uart_valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_idle: ready=%b valid=%b, want 1 0", bus.ready_o, bus.uart_valid_o);
    end
    for (int i = 0; i < NBT; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      vec_cnt++;
      if (bus.uart_valid_o !== 1'b1 || bus.data_uart_o !== exp_byte(wb, i)) begin
        err_cnt++;
        $display("FAIL b2b_b%0d: valid=%b byte=%h, want 1 %h",
                 i, bus.uart_valid_o, bus.data_uart_o, exp_byte(wb, i));
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.split_finished_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL b2b_done_b: fin=%b want 1", bus.split_finished_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w;
    w = 32'h12345678;
    bus.data_i = w;
    bus.start_i = 1'b1;
    bus.uart_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.start_i = 1'b0;
    vec_cnt++;
    if (bus.data_uart_o !== exp_byte(w, 2)) begin
      err_cnt++;
      $display("FAIL rmid_pre: byte=%h want %h", bus.data_uart_o, exp_byte(w, 2));
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus.uart_valid_o !== 1'b0 || bus.ready_o !== 1'b1 ||
        bus.data_uart_o !== 8'h00 || bus.split_finished_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL rmid_async: valid=%b ready=%b byte=%h fin=%b, want 0 1 00 0",
               bus.uart_valid_o, bus.ready_o, bus.data_uart_o, bus.split_finished_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (bus.split_finished_o !== 1'b0 || bus.uart_valid_o !== 1'b0) begin
        err_cnt++;
        $display("FAIL rmid_quiet%0d: fin=%b valid=%b, want 0 0",
                 i, bus.split_finished_o, bus.uart_valid_o);
      end
    end
    w = 32'hCAFEBABE;
    bus.data_i = w;
    bus.start_i = 1'b1;
    for (int i = 0; i < NBT; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      vec_cnt++;
      if (bus.uart_valid_o !== 1'b1 || bus.data_uart_o !== exp_byte(w, i)) begin
        err_cnt++;
        $display("FAIL rmid_next%0d: valid=%b byte=%h, want 1 %h",
                 i, bus.uart_valid_o, bus.data_uart_o, exp_byte(w, i));
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.split_finished_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL rmid_done: fin=%b want 1", bus.split_finished_o);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [31:0] w;
    w = 32'h12345678;
    bus.data_i = w;
    bus.start_i = 1'b1;
    bus.uart_ready_i = 1'b1;
    for (int i = 0; i < NBT; i++) begin
      @(negedge clk);
      bus.data_i = 32'hDEADBEEF;
      vec_cnt++;
      if (bus.data_uart_o !== exp_byte(w, i) || bus.ready_o !== 1'b0) begin
        err_cnt++;
        $display("FAIL ign_byte%0d: byte=%h ready=%b, want %h 0",
                 i, bus.data_uart_o, bus.ready_o, exp_byte(w, i));
      end
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    vec_cnt++;
    if (bus.split_finished_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL ign_done: fin=%b want 1", bus.split_finished_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (bus.uart_valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
        err_cnt++;
        $display("FAIL ign_idle%0d: valid=%b ready=%b, want 0 1",
                 i, bus.uart_valid_o, bus.ready_o);
      end
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_ignore_start();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
